rect_fill_engine: RTL

Hardware rectangle-draw engine for the VGA video RAM path. It replaces the software pixel loop (MOV/VGA/INC/BLE sequences) the CPU currently runs per rectangle. The CPU or a controller supplies corner coordinates, a colour and a mode, then pulses start. The engine streams one pixel write per accepted cycle to the video RAM write port and signals completion.

---
 rtl/rect_fill_engine_if.sv | 46 ++++
 rtl/rect_fill_engine.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine_if.sv
// rect_fill_engine_if
//
// Bundles the command inputs and the video RAM write port of rect_fill_engine.
//
// Handshake: the write port is a valid/ready pair. oWriteEnable is valid and
// iWriteReady is ready. A pixel write (oX, oY, oColor) transfers on every
// rising edge where both are 1. While valid is high and ready is low, the
// engine holds oX/oY/oColor stable and keeps valid high. Valid never drops
// until the transfer completes.
//
// Modports:
//   master - command/RAM side: drives iStart, iXi, iXf, iYi, iYf, iColor,
//            iMode, iWriteReady; observes the engine outputs
//   slave  - the engine: consumes the command and drives oWriteEnable, oX,
//            oY, oColor, oBusy, oDone, oError
interface rect_fill_engine_if #(
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 8,
  parameter int COLOR_WIDTH = 3
);
  logic                   iStart;
  logic [X_WIDTH-1:0]     iXi;
  logic [X_WIDTH-1:0]     iXf;
  logic [Y_WIDTH-1:0]     iYi;
  logic [Y_WIDTH-1:0]     iYf;
  logic [COLOR_WIDTH-1:0] iColor;
  logic                   iMode;
  logic                   iWriteReady;
  logic                   oWriteEnable;
  logic [X_WIDTH-1:0]     oX;
  logic [Y_WIDTH-1:0]     oY;
  logic [COLOR_WIDTH-1:0] oColor;
  logic                   oBusy;
  logic                   oDone;
  logic                   oError;

  modport master (
    output iStart, iXi, iXf, iYi, iYf, iColor, iMode, iWriteReady,
    input  oWriteEnable, oX, oY, oColor, oBusy, oDone, oError
  );

  modport slave (
    input  iStart, iXi, iXf, iYi, iYf, iColor, iMode, iWriteReady,
    output oWriteEnable, oX, oY, oColor, oBusy, oDone, oError
  );
endinterface

// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//
// Hardware rectangle draw for the VGA video RAM path. A start command latches
// the corner coordinates, colour and mode (0 = solid fill, 1 = outline). The
// engine then streams one pixel write per accepted cycle in raster order and
// pulses oDone when the last pixel is accepted. Empty rectangles finish at once
// with oError set.
//
// Optional feature: define RECT_FILL_CLIP_EN to clamp x coordinates to X_MAX
// and y coordinates to Y_MAX before the empty check. Without this feature, the
// caller keeps coordinates on screen.
//
// Ports:
//   Clock     - system clock, rising edge
//   Reset     - asynchronous, active-low; aborts any rectangle and clears outputs
//   bus       - rect_fill_engine_if.slave (command inputs, RAM write port,
//               status oBusy/oDone/oError)
//   dbg_state - current FSM state (0 IDLE, 1 DRAW, 2 DONE)
module rect_fill_engine #(
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 8,
  parameter int COLOR_WIDTH = 3,
  parameter int X_MAX       = 79,
  parameter int Y_MAX       = 59
) (
  input  logic                Clock,
  input  logic                Reset,
  rect_fill_engine_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The screen limits must be representable in the coordinate width.
  if (X_MAX >= (2 ** X_WIDTH) || Y_MAX >= (2 ** Y_WIDTH)) begin : g_max_range_check
    $error("rect_fill_engine: X_MAX/Y_MAX do not fit the coordinate width");
  end

`ifdef RECT_FILL_CLIP_EN
  localparam logic [X_WIDTH-1:0] X_LIM = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_LIM = Y_WIDTH'(Y_MAX);
`endif

  state_t             state;
  logic [X_WIDTH-1:0] xi_q;
  logic [X_WIDTH-1:0] xf_q;
  logic [Y_WIDTH-1:0] yi_q;
  logic [Y_WIDTH-1:0] yf_q;
  logic               mode_q;

  logic [X_WIDTH-1:0] start_xi;
  logic [X_WIDTH-1:0] start_xf;
  logic [Y_WIDTH-1:0] start_yi;
  logic [Y_WIDTH-1:0] start_yf;
  logic               start_empty;
  logic               edge_row;
  logic               row_end;
  logic               last_pix;
  logic [X_WIDTH-1:0] next_x;

  assign dbg_state = state;

  always_comb begin
    start_xi = bus.iXi;
    start_xf = bus.iXf;
    start_yi = bus.iYi;
    start_yf = bus.iYf;
`ifdef RECT_FILL_CLIP_EN
    if (bus.iXi > X_LIM) start_xi = X_LIM;
    if (bus.iXf > X_LIM) start_xf = X_LIM;
    if (bus.iYi > Y_LIM) start_yi = Y_LIM;
    if (bus.iYf > Y_LIM) start_yf = Y_LIM;
`endif
    start_empty = (start_xi > start_xf) || (start_yi > start_yf);

    // x never passes xf, so ">=" marks the last column of the row. Because
    // next_x is only used below xf, x+1 cannot wrap even when xf is at the
    // top of the coordinate range.
    edge_row = (bus.oY == yi_q) || (bus.oY == yf_q);
    row_end  = (bus.oX >= xf_q);
    last_pix = row_end && (bus.oY == yf_q);

    // Outline interior rows only visit xi and xf. Below xf, x is xi, so the
    // next pixel jumps straight to xf.
    if (mode_q && !edge_row) next_x = xf_q;
    else                     next_x = bus.oX + 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= S_IDLE;
      xi_q             <= '0;
      xf_q             <= '0;
      yi_q             <= '0;
      yf_q             <= '0;
      mode_q           <= 1'b0;
      bus.oWriteEnable <= 1'b0;
      bus.oX           <= '0;
      bus.oY           <= '0;
      bus.oColor       <= '0;
      bus.oBusy        <= 1'b0;
      bus.oDone        <= 1'b0;
      bus.oError       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.iStart) begin
            xi_q       <= start_xi;
            xf_q       <= start_xf;
            yi_q       <= start_yi;
            yf_q       <= start_yf;
            mode_q     <= bus.iMode;
            bus.oColor <= bus.iColor;
            bus.oX     <= start_xi;
            bus.oY     <= start_yi;
            bus.oBusy  <= 1'b1;
            bus.oError <= start_empty;
            if (start_empty) begin
              bus.oDone <= 1'b1;
              state     <= S_DONE;
            end else begin
              bus.oWriteEnable <= 1'b1;
              state            <= S_DRAW;
            end
          end
        end

        S_DRAW: begin
          // oWriteEnable is 1 throughout DRAW, so ready alone means accepted.
          if (bus.iWriteReady) begin
            if (last_pix) begin
              bus.oWriteEnable <= 1'b0;
              bus.oDone        <= 1'b1;
              state            <= S_DONE;
            end else if (row_end) begin
              bus.oX <= xi_q;
              bus.oY <= bus.oY + 1'b1;
            end else begin
              bus.oX <= next_x;
            end
          end
        end

        S_DONE: begin
          bus.oDone <= 1'b0;
          bus.oBusy <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
